// File: rtl/apb_uart_cmd_master_if.sv
// Command, response and APB3 signals between a local controller, the command master and its slaves.
interface apb_uart_cmd_master_if #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned SEL_W      = 4
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [SEL_W-1:0]      CMD_SEL;
    logic [ADDR_W-1:0]     CMD_ADDR;
    logic [DATA_W-1:0]     CMD_WDATA;
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [DATA_W-1:0]     RSP_RDATA;
    logic                  RSP_ERR;
    logic                  RSP_TIMEOUT;
    logic [ADDR_W-1:0]     PADDR;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // Command master side: accepts commands, drives APB, returns responses.
    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_SEL, CMD_ADDR, CMD_WDATA, RSP_READY,
               PRDATA, PREADY, PSLVERR,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    // Environment side: command source, response sink and APB slaves.
    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_SEL, CMD_ADDR, CMD_WDATA, RSP_READY,
               PRDATA, PREADY, PSLVERR,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_uart_cmd_master.sv
// APB3 initiator: turns a valid/ready command into one APB transfer to a selected slave
// and returns read data / error status on a held response channel.
module apb_uart_cmd_master #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_uart_cmd_master_if.master bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    // Counter value seen on the last allowed wait cycle before aborting.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    // State and output registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a state changes it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.CMD_VALID && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    pwrite_d    = bus.CMD_WRITE;
                    paddr_d     = bus.CMD_ADDR;
                    pwdata_d    = bus.CMD_WDATA;
                    if (32'(bus.CMD_SEL) < NUM_SLAVES) begin
                        psel_d  = NUM_SLAVES'(1) << bus.CMD_SEL;
                        cnt_d   = '0;
                        state_d = SETUP;
                    end else begin
                        // Out-of-range select: answer with an error, never touch the bus.
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                        state_d       = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.CMD_READY   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_RDATA   = rsp_rdata_q;
    assign bus.RSP_ERR     = rsp_err_q;
    assign bus.RSP_TIMEOUT = rsp_timeout_q;
endmodule

// File: doc/apb_uart_cmd_master.md
Name: apb_uart_cmd_master

Overview:
Hardware APB initiator that turns a simple valid/ready command stream into APB3 transfers to one of several CoreUARTapb-style slaves (5-bit address, 8-bit data). It replaces the BFM when a UART subsystem is driven from a local controller instead of a processor bus. It drives the APB address/control signals and per-slave one-hot PSEL, waits on PREADY with a bounded timeout, and returns read data and error status on a held response channel.

Parameters:
NUM_SLAVES, 2, number of PSEL outputs (1..16)
SEL_W, 4, width of CMD_SEL (must satisfy 2^SEL_W >= NUM_SLAVES)
TIMEOUT, 16, max PREADY-low cycles in ACCESS before abort; 0 disables the timeout
CNT_W, 8, wait counter width (must satisfy 2^CNT_W > TIMEOUT)

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  synchronous active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  command accepted when VALID&READY
CMD_WRITE  in  1  1=write, 0=read
CMD_SEL  in  SEL_W  target slave index
CMD_ADDR  in  5  APB register address
CMD_WDATA  in  8  write data
RSP_VALID  out  1  response held until RSP_READY
RSP_READY  in  1  response consumer ready
RSP_RDATA  out  8  read data (0 for writes/aborts)
RSP_ERR  out  1  PSLVERR, bad select, or timeout
RSP_TIMEOUT  out  1  abort due to timeout
PADDR  out  5  APB address
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PWDATA  out  8  APB write data
PRDATA  in  8  muxed slave read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Clock PCLK; reset PRESET is synchronous, active-high (fixed). While PRESET=1 at a rising edge: state=IDLE, all outputs 0 (including CMD_READY, PSEL, PENABLE, PADDR, PWDATA, PWRITE, RSP_*), wait counter 0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1. On CMD_VALID=1, capture WRITE/SEL/ADDR/WDATA into PWRITE/PADDR/PWDATA. If SEL<NUM_SLAVES -> SETUP; else -> RESP with RSP_ERR=1, RSP_RDATA=0, no APB activity.
- SETUP (1 cycle): PSEL[sel]=1, PENABLE=0, CMD_READY=0 -> ACCESS.
- ACCESS: PSEL[sel]=1, PENABLE=1. PADDR/PWRITE/PWDATA stable through SETUP and ACCESS.
  - PREADY=1: RSP_RDATA=PRDATA for reads, 0 for writes; RSP_ERR=PSLVERR; RSP_TIMEOUT=0; drop PSEL/PENABLE -> RESP.
  - PREADY=0: counter++. If TIMEOUT!=0 and counter==TIMEOUT-1 when PREADY is still 0 (i.e. TIMEOUT wait cycles elapsed), abort: RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0, drop PSEL/PENABLE -> RESP.
  - Counter clears on entry to SETUP.
- RESP: RSP_VALID=1; RSP_* held stable until RSP_VALID&RSP_READY, then RSP_VALID=0 -> IDLE. CMD_READY=0 in RESP.
- Latency: command accepted at edge 0 -> PSEL at 1 -> PENABLE at 2 -> RSP_VALID at 3 (zero-wait slave). Throughput with RSP_READY tied high: one transfer per 4 cycles.
- PADDR/PWDATA/PWRITE retain their last values after a transfer. PSEL/PENABLE are 0 in IDLE and RESP.
- Outputs are registered; no combinational path from PREADY/PRDATA to any output.
- Reset mid-transfer: PSEL/PENABLE drop at that edge, and a pending response is discarded.

Test Plan:
- Write SEL=0 ADDR=0x00 WDATA=0xA5, PREADY=1 -> PSEL=01 for 2 cycles, PENABLE in 2nd, PWDATA=0xA5; RSP_VALID at cycle 3, ERR=0, RDATA=0x00.
- Read SEL=1 ADDR=0x10, PRDATA=0x3C, PREADY low 3 cycles -> PSEL=10 for 5 cycles; RSP_RDATA=0x3C, ERR=0, TIMEOUT=0.
- TIMEOUT=16, PREADY held 0 -> abort after 16 ACCESS wait cycles; RSP_ERR=1, RSP_TIMEOUT=1, PSEL=0 next cycle.
- CMD_SEL=5 with NUM_SLAVES=2 -> no PSEL activity; RSP_VALID next cycle with ERR=1, RDATA=0.
- PSLVERR=1 with PREADY; RSP_READY held 0 for 4 cycles -> RSP_ERR=1 held stable and CMD_READY=0 throughout; IDLE after handshake.
- PRESET asserted during ACCESS -> PSEL/PENABLE/RSP_VALID=0 at that edge, CMD_READY=1 one cycle after release.
